// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared op encodings and Booth radix-8 helpers for booth_mul_pipe
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  localparam int BOOTH_GROUP_BITS = 3;
  localparam int BOOTH_SEL_W      = BOOTH_GROUP_BITS + 1;

  // ceil((w+1)/3): one extra multiplier bit keeps unsigned operands positive
  function automatic int booth_groups(input int w);
    return (w + 3) / 3;
  endfunction

endpackage

// File: rtl/booth_r8_pp.sv
// rtl/booth_r8_pp.sv - radix-8 Booth partial-product selector for one multiplier group
module booth_r8_pp
  import mul_pkg::*;
#(
  parameter int PW = 64
) (
  input  logic [PW-1:0]          a_ext_i,
  input  logic [PW-1:0]          a3_i,
  input  logic [BOOTH_SEL_W-1:0] sel_i,
  output logic [PW-1:0]          pp_o
);

  logic [PW-1:0] mag;

  always_comb begin
    mag = '0;
    case (sel_i)
      4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = a_ext_i;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = a_ext_i << 1;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = a3_i;
      4'b0111, 4'b1000:                   mag = a_ext_i << 2;
      default:                            mag = '0;
    endcase
    // top select bit carries the negative weight of the group
    pp_o = sel_i[3] ? -mag : mag;
  end

endmodule

// File: rtl/booth_mul_pipe.sv
// rtl/booth_mul_pipe.sv - 3-stage radix-8 Booth multiplier for RV32M ops with valid/ready and flush
// MUL_IN_REG_EN adds an input register stage ahead of Booth decode (latency 4).
module booth_mul_pipe
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int W    = DATA_WIDTH;
  localparam int NG   = booth_groups(W);
  localparam int BW   = BOOTH_GROUP_BITS * NG;
  localparam int PW   = 2 * W;
  localparam int NSUM = 4;

  logic adv, accept;
  logic out_valid_q;

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv & ~flush;
  assign accept    = in_valid & in_ready;

  logic                 src_v;
  logic [1:0]           src_op;
  logic [W-1:0]         src_a, src_b;
  logic [TAG_WIDTH-1:0] src_tag;

`ifdef MUL_IN_REG_EN
  logic                 v0_q;
  logic [1:0]           op0_q;
  logic [W-1:0]         a0_q, b0_q;
  logic [TAG_WIDTH-1:0] tag0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      op0_q  <= '0;
      a0_q   <= '0;
      b0_q   <= '0;
      tag0_q <= '0;
    end else if (flush) begin
      v0_q <= 1'b0;
    end else if (adv) begin
      v0_q <= accept;
      if (accept) begin
        op0_q  <= op;
        a0_q   <= a;
        b0_q   <= b;
        tag0_q <= in_tag;
      end
    end
  end

  assign src_v   = v0_q;
  assign src_op  = op0_q;
  assign src_a   = a0_q;
  assign src_b   = b0_q;
  assign src_tag = tag0_q;
`else
  assign src_v   = accept;
  assign src_op  = op;
  assign src_a   = a;
  assign src_b   = b;
  assign src_tag = in_tag;
`endif

  logic          a_s, b_s;
  logic [PW-1:0] a_ext, a3;
  logic [BW:0]   b_pad;

  assign a_s   = (src_op == MUL_OP_MULH) || (src_op == MUL_OP_MULHSU);
  assign b_s   = (src_op == MUL_OP_MULH);
  assign a_ext = {{W{a_s & src_a[W-1]}}, src_a};
  // multiplier extended to BW bits with an implicit zero below bit 0
  assign b_pad = {{(BW-W){b_s & src_b[W-1]}}, src_b, 1'b0};
  assign a3    = a_ext + (a_ext << 1);

  logic [PW-1:0] pp_sh [NG];

  for (genvar g = 0; g < NG; g++) begin : g_pp
    logic [PW-1:0] pp;
    booth_r8_pp #(.PW(PW)) u_pp (
      .a_ext_i (a_ext),
      .a3_i    (a3),
      .sel_i   (b_pad[3*g+3:3*g]),
      .pp_o    (pp)
    );
    assign pp_sh[g] = pp << (3*g);
  end

  logic [PW-1:0] s1_d [NSUM];

  always_comb begin
    for (int k = 0; k < NSUM; k++) s1_d[k] = '0;
    for (int g = 0; g < NG; g++) s1_d[g % NSUM] = s1_d[g % NSUM] + pp_sh[g];
  end

  logic                 v1_q, v2_q;
  logic [PW-1:0]        s1_q [NSUM];
  logic [PW-1:0]        s2_q [2];
  logic [1:0]           op1_q, op2_q;
  logic [TAG_WIDTH-1:0] tag1_q, tag2_q, out_tag_q;
  logic [PW-1:0]        product_q, sum3;
  logic [W-1:0]         result_q;

  assign sum3 = s2_q[0] + s2_q[1];

  // data registers load only with a valid op so held outputs never change under a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < NSUM; k++) s1_q[k] <= '0;
      s2_q[0]     <= '0;
      s2_q[1]     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      product_q   <= '0;
      result_q    <= '0;
      out_tag_q   <= '0;
    end else if (flush) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      v1_q        <= src_v;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (src_v) begin
        for (int k = 0; k < NSUM; k++) s1_q[k] <= s1_d[k];
        op1_q  <= src_op;
        tag1_q <= src_tag;
      end
      if (v1_q) begin
        s2_q[0] <= s1_q[0] + s1_q[1];
        s2_q[1] <= s1_q[2] + s1_q[3];
        op2_q   <= op1_q;
        tag2_q  <= tag1_q;
      end
      if (v2_q) begin
        product_q <= sum3;
        result_q  <= (op2_q == MUL_OP_MUL) ? sum3[W-1:0] : sum3[PW-1:W];
        out_tag_q <= tag2_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign product   = product_q;
  assign out_tag   = out_tag_q;

endmodule
